// File: rtl/seq_divider_if.sv
// Start/finish handshake bundle for the sequential divider.
// Operands flow master->slave; results and status flow back.
interface seq_divider_if #(
    parameter int unsigned LEN = 32
);
    logic [LEN-1:0] dividend;
    logic [LEN-1:0] divisor;
    logic           start;
    logic [LEN-1:0] quotient;
    logic [LEN-1:0] remainder;
    logic           div_by_zero;
    logic           busy;
    logic           finish;

    modport master (
        output dividend, divisor, start,
        input  quotient, remainder, div_by_zero, busy, finish
    );

    modport slave (
        input  dividend, divisor, start,
        output quotient, remainder, div_by_zero, busy, finish
    );
endinterface

// File: rtl/seq_divider.sv
// Unsigned restoring divider, one quotient bit per clock.
// Shares the IDLE/WORK/FINAL start/finish handshake with the shift-add multiplier.
module seq_divider #(
    parameter int unsigned LEN = 32
) (
    input logic         clk,
    input logic         rst,
    seq_divider_if.slave bus
);
    localparam int unsigned CntW = $clog2(LEN + 1);

    typedef enum logic [1:0] {StIdle, StWork, StFinal} state_e;

    state_e         r_state;
    state_e         w_state_next;
    logic [CntW-1:0] r_count;
    logic [LEN-1:0] r_divisor;
    logic [LEN-1:0] r_q;
    logic [LEN:0]   r_rem;
    logic [LEN-1:0] r_quotient;
    logic [LEN-1:0] r_remainder;
    logic           r_dbz;
    logic           r_finish;
    logic [LEN:0]   w_shifted;
    logic [LEN:0]   w_diff;
    logic           w_last;

    assign w_shifted = {r_rem[LEN-1:0], r_q[LEN-1]};
    assign w_diff    = w_shifted - {1'b0, r_divisor};
    assign w_last    = (r_count == CntW'(LEN - 1));

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (bus.start) w_state_next = StWork;
            StWork:  if (w_last) w_state_next = StFinal;
            StFinal: w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count     <= '0;
            r_divisor   <= '0;
            r_q         <= '0;
            r_rem       <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
            r_finish    <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    r_finish <= 1'b0;
                    if (bus.start) begin
                        r_divisor <= bus.divisor;
                        r_q       <= bus.dividend;
                        r_rem     <= '0;
                        r_count   <= '0;
                    end
                end
                StWork: begin
                    // Negative difference means the trial subtraction is undone.
                    if (!w_diff[LEN]) begin
                        r_rem <= w_diff;
                    end else begin
                        r_rem <= w_shifted;
                    end
                    r_q     <= {r_q[LEN-2:0], ~w_diff[LEN]};
                    r_count <= r_count + CntW'(1);
                end
                StFinal: begin
                    r_quotient  <= r_q;
                    r_remainder <= r_rem[LEN-1:0];
                    r_dbz       <= (r_divisor == '0);
                    r_finish    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.quotient    = r_quotient;
    assign bus.remainder   = r_remainder;
    assign bus.div_by_zero = r_dbz;
    assign bus.finish      = r_finish;
    assign bus.busy        = (r_state != StIdle);
endmodule

// File: tb/tb_seq_divider.sv
// Randomised self-checking bench for seq_divider against an arithmetic reference model.
module tb_seq_divider;
    localparam int unsigned LEN = 32;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;

    seq_divider_if #(.LEN(LEN)) bus ();

    seq_divider #(.LEN(LEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [LEN-1:0] ref_q(input logic [LEN-1:0] a, input logic [LEN-1:0] b);
        return (b == 0) ? '1 : a / b;
    endfunction

    function automatic logic [LEN-1:0] ref_r(input logic [LEN-1:0] a, input logic [LEN-1:0] b);
        return (b == 0) ? a : a % b;
    endfunction

    // Issue one operation and wait (bounded) for its finish pulse.
    task automatic do_op(input logic [LEN-1:0] a, input logic [LEN-1:0] b,
                         output logic [LEN-1:0] q, output logic [LEN-1:0] r,
                         output logic z, output int lat, output int busy_n);
        @(negedge clk);
        bus.dividend = a;
        bus.divisor  = b;
        bus.start    = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        busy_n = bus.busy ? 1 : 0;
        lat = 0;
        while (lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.finish) break;
            if (bus.busy) busy_n++;
        end
        q = bus.quotient;
        r = bus.remainder;
        z = bus.div_by_zero;
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
        rst = 1'b0;
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({bus.busy, bus.finish, bus.div_by_zero} !== 3'b000 || bus.quotient !== '0 ||
            bus.remainder !== '0) begin
            n_fail++;
            $display("FAIL reset: got busy=%b fin=%b dbz=%b q=%0h r=%0h required all 0",
                     bus.busy, bus.finish, bus.div_by_zero, bus.quotient, bus.remainder);
        end
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [LEN-1:0] q, r; logic z; int lat, bn;
        do_op(32'd100, 32'd7, q, r, z, lat, bn);
        n_cmp++;
        if (lat !== LEN + 1) begin
            n_fail++; $display("FAIL basic_latency: got %0d edges required %0d", lat, LEN + 1);
        end
        n_cmp++;
        if (bn !== LEN + 1) begin
            n_fail++; $display("FAIL basic_busy: got %0d cycles required %0d", bn, LEN + 1);
        end
        n_cmp++;
        if (q !== 32'd14 || r !== 32'd2 || z !== 1'b0) begin
            n_fail++; $display("FAIL basic_result: got q=%0d r=%0d z=%b required 14 2 0", q, r, z);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (bus.finish !== 1'b0) begin
            n_fail++; $display("FAIL basic_pulse: got finish=%b one cycle later required 0", bus.finish);
        end
    endtask

    task automatic test_boundaries();
        logic [LEN-1:0] va [3];
        logic [LEN-1:0] vb [3];
        logic [LEN-1:0] q, r; logic z; int lat, bn;
        va[0] = 32'hFFFF_FFFF; vb[0] = 32'd1;
        va[1] = 32'hFFFF_FFFF; vb[1] = 32'hFFFF_FFFF;
        va[2] = 32'd5;         vb[2] = 32'd9;
        for (int i = 0; i < 3; i++) begin
            do_op(va[i], vb[i], q, r, z, lat, bn);
            n_cmp++;
            if (q !== ref_q(va[i], vb[i]) || r !== ref_r(va[i], vb[i]) || z !== 1'b0) begin
                n_fail++;
                $display("FAIL boundary_%0d: got q=%0h r=%0h z=%b required q=%0h r=%0h z=0",
                         i, q, r, z, ref_q(va[i], vb[i]), ref_r(va[i], vb[i]));
            end
        end
    endtask

    task automatic test_div_zero();
        logic [LEN-1:0] q, r; logic z; int lat, bn;
        do_op(32'd1234, 32'd0, q, r, z, lat, bn);
        n_cmp++;
        if (lat !== LEN + 1 || q !== 32'hFFFF_FFFF || r !== 32'd1234 || z !== 1'b1) begin
            n_fail++;
            $display("FAIL div_zero: got lat=%0d q=%0h r=%0d z=%b required %0d ffffffff 1234 1",
                     lat, q, r, z, LEN + 1);
        end
        do_op(32'd10, 32'd3, q, r, z, lat, bn);
        n_cmp++;
        if (q !== 32'd3 || r !== 32'd1 || z !== 1'b0) begin
            n_fail++; $display("FAIL dbz_clear: got q=%0d r=%0d z=%b required 3 1 0", q, r, z);
        end
    endtask

    task automatic test_busy_ignore();
        int pulses;
        logic [LEN-1:0] q, r;
        pulses = 0; q = '0; r = '0;
        @(negedge clk);
        bus.dividend = 32'd10; bus.divisor = 32'd3; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        bus.dividend = 32'd50; bus.divisor = 32'd5; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0; bus.dividend = 32'd77; bus.divisor = 32'd2;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            if (bus.finish) begin
                pulses++; q = bus.quotient; r = bus.remainder;
            end
        end
        n_cmp++;
        if (pulses !== 1) begin
            n_fail++; $display("FAIL ignore_pulses: got %0d finish pulses required 1", pulses);
        end
        n_cmp++;
        if (q !== 32'd3 || r !== 32'd1) begin
            n_fail++; $display("FAIL ignore_result: got q=%0d r=%0d required 3 1", q, r);
        end
    endtask

    task automatic test_async_reset();
        logic [LEN-1:0] q, r; logic z; int lat, bn;
        @(negedge clk);
        bus.dividend = 32'd100; bus.divisor = 32'd7; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.finish !== 1'b0 || bus.quotient !== '0 ||
            bus.remainder !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got busy=%b fin=%b q=%0h r=%0h required all 0",
                     bus.busy, bus.finish, bus.quotient, bus.remainder);
        end
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        do_op(32'd81, 32'd9, q, r, z, lat, bn);
        n_cmp++;
        if (lat !== LEN + 1 || q !== 32'd9 || r !== 32'd0) begin
            n_fail++;
            $display("FAIL after_reset: got lat=%0d q=%0d r=%0d required %0d 9 0", lat, q, r, LEN + 1);
        end
    endtask

    task automatic test_back_to_back();
        int cyc, last, seen;
        cyc = 0; last = -1; seen = 0;
        @(negedge clk);
        bus.dividend = 32'd1000; bus.divisor = 32'd33; bus.start = 1'b1;
        for (int i = 0; i < 4 * (LEN + 2) + 4; i++) begin
            @(posedge clk); #1;
            cyc++;
            if (bus.finish) begin
                seen++;
                n_cmp++;
                if (bus.quotient !== 32'd30 || bus.remainder !== 32'd10) begin
                    n_fail++;
                    $display("FAIL b2b_result: got q=%0d r=%0d required 30 10",
                             bus.quotient, bus.remainder);
                end
                if (last >= 0) begin
                    n_cmp++;
                    if (cyc - last !== LEN + 2) begin
                        n_fail++;
                        $display("FAIL b2b_period: got %0d cycles required %0d", cyc - last, LEN + 2);
                    end
                end
                last = cyc;
            end
        end
        n_cmp++;
        if (seen < 3) begin
            n_fail++; $display("FAIL b2b_count: got %0d pulses required at least 3", seen);
        end
        @(negedge clk) bus.start = 1'b0;
        for (int i = 0; i < 100 && bus.busy; i++) @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        logic [LEN-1:0] a, b, q, r; logic z; int lat, bn;
        logic [2*LEN-1:0] recon;
        for (int i = 0; i < 200; i++) begin
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = $urandom_range(0, 15);
                1: b = $urandom >> $urandom_range(0, 31);
                default: b = $urandom;
            endcase
            do_op(a, b, q, r, z, lat, bn);
            n_cmp++;
            if (lat !== LEN + 1 || q !== ref_q(a, b) || r !== ref_r(a, b) || z !== (b == 0)) begin
                n_fail++;
                $display("FAIL random_%0d: %0h/%0h got q=%0h r=%0h z=%b lat=%0d required q=%0h r=%0h z=%b",
                         i, a, b, q, r, z, lat, ref_q(a, b), ref_r(a, b), (b == 0));
            end
            if (b != 0) begin
                recon = {{LEN{1'b0}}, q} * {{LEN{1'b0}}, b} + {{LEN{1'b0}}, r};
                n_cmp++;
                if (recon !== {{LEN{1'b0}}, a} || r >= b) begin
                    n_fail++;
                    $display("FAIL invariant_%0d: got q*d+r=%0h r=%0h required %0h with r<%0h",
                             i, recon, r, a, b);
                end
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        test_reset();
        test_basic();
        test_boundaries();
        test_div_zero();
        test_busy_ignore();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
